reduce_accum: RTL and testbench

- Downstream consumer of the row of multiply switches.
- Takes NUM_IN per-switch products with per-lane valid and sums them through a pipelined binary adder tree.
- Temporally accumulates ACC_LEN consecutive tree results into one output partial sum.
- Feeds the output/writeback collector with a single valid-qualified wide result.

---
 rtl/reduce_accum.sv | 151 +++++++++++++++
 tb/tb_reduce_accum.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_accum.sv
// Pipelined adder-tree reduction of NUM_IN masked, sign-extended products,
// followed by a temporal accumulator that emits one sum per acc_len tree results.
module reduce_accum #(
    parameter int NUM_IN        = 8,
    parameter int IN_DATA_TYPE  = 32,
    parameter int OUT_DATA_TYPE = 40,
    parameter int LEN_W         = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IN-1:0]                i_valid,
    input  logic [NUM_IN*IN_DATA_TYPE-1:0]   i_data,
    input  logic                             i_cfg_valid,
    input  logic [LEN_W-1:0]                 i_acc_len,
    output logic                             o_valid,
    output logic [OUT_DATA_TYPE-1:0]         o_data,
    output logic                             o_busy
);

    localparam int LEVELS = $clog2(NUM_IN);
    localparam int EXT_W  = OUT_DATA_TYPE - IN_DATA_TYPE;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Masked, sign-extended leaves of the tree.
    logic [OUT_DATA_TYPE-1:0] lane [NUM_IN];

    genvar k;
    generate
        for (k = 0; k < NUM_IN; k++) begin : g_lane
            assign lane[k] = i_valid[k]
                ? {{EXT_W{i_data[k*IN_DATA_TYPE+IN_DATA_TYPE-1]}}, i_data[k*IN_DATA_TYPE +: IN_DATA_TYPE]}
                : '0;
        end
    endgenerate

    // Heap-ordered tree nodes: node 1 is the root, children of n are 2n and 2n+1.
    // Nodes at the same depth share one pipeline stage.
    logic [OUT_DATA_TYPE-1:0] node [1:NUM_IN-1];

    genvar n;
    generate
        for (n = 1; n < NUM_IN; n++) begin : g_node
            if (2 * n >= NUM_IN) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) node[n] <= '0;
                    else     node[n] <= lane[2*n-NUM_IN] + lane[2*n+1-NUM_IN];
                end
            end else begin : g_inner
                always_ff @(posedge clk) begin
                    if (rst) node[n] <= '0;
                    else     node[n] <= node[2*n] + node[2*n+1];
                end
            end
        end
    endgenerate

    logic [LEVELS-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= |i_valid;
            for (int s = 1; s < LEVELS; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    logic                     tree_valid;
    logic [OUT_DATA_TYPE-1:0] tree_sum;

    assign tree_valid = vld_q[LEVELS-1];
    assign tree_sum   = node[1];

    state_t                   state_q, state_d;
    logic [OUT_DATA_TYPE-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     out_valid_d;
    logic [OUT_DATA_TYPE-1:0] out_data_d;

    assign o_busy = (|vld_q) || (state_q == ACCUM);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = 1'b0;
        out_data_d  = o_data;

        // Length changes only land between groups, never under a group in flight.
        if (i_cfg_valid && !o_busy && !(|i_valid)) begin
            len_d = (i_acc_len == '0) ? LEN_W'(1) : i_acc_len;
        end

        case (state_q)
            IDLE: begin
                if (tree_valid) begin
                    if (len_q == LEN_W'(1)) begin
                        out_data_d  = tree_sum;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d   = tree_sum;
                        cnt_d   = LEN_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (tree_valid) begin
                    if ((cnt_q + LEN_W'(1)) < len_q) begin
                        acc_d = acc_q + tree_sum;
                        cnt_d = cnt_q + LEN_W'(1);
                    end else begin
                        out_data_d  = acc_q + tree_sum;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_W'(1);
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            o_valid <= out_valid_d;
            o_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_reduce_accum.sv
// Bench for reduce_accum: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a group-level arithmetic model.
module tb_reduce_accum;

    localparam int N   = 8;
    localparam int IW  = 32;
    localparam int OW  = 40;
    localparam int LW  = 16;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      i_valid;
    logic [N*IW-1:0]   i_data;
    logic              i_cfg_valid;
    logic [LW-1:0]     i_acc_len;
    logic              o_valid;
    logic [OW-1:0]     o_data;
    logic              o_busy;

    reduce_accum #(
        .NUM_IN(N), .IN_DATA_TYPE(IW), .OUT_DATA_TYPE(OW), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .i_cfg_valid(i_cfg_valid), .i_acc_len(i_acc_len),
        .o_valid(o_valid), .o_data(o_data), .o_busy(o_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / model state ----------------
    logic [OW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 0;
    int            pulse_cnt = 0;
    logic [OW-1:0] last_seen = '0;
    logic [OW-1:0] last_out  = '0;
    int            len_m     = 1;
    int            cnt_m     = 0;
    logic [OW-1:0] g_sum     = '0;
    int            last_beat = -100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] beat_sum(input logic [N-1:0] v, input logic [N*IW-1:0] d);
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) begin
            if (v[k]) s += longint'($signed(d[k*IW +: IW]));
        end
        return s[OW-1:0];
    endfunction

    function automatic bit busy_m();
        return (cnt_m != 0) || (last_beat >= cyc - 3 && last_beat < cyc);
    endfunction

    function automatic logic [N*IW-1:0] all_lanes(input logic [IW-1:0] v);
        logic [N*IW-1:0] d;
        for (int k = 0; k < N; k++) d[k*IW +: IW] = v;
        return d;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        exp_cyc_q.delete();
        last_out  = '0;
        len_m     = 1;
        cnt_m     = 0;
        g_sum     = '0;
        last_beat = -100;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N*IW-1:0] d,
                               input logic cv, input logic [LW-1:0] len);
        @(negedge clk);
        check("busy", o_busy, busy_m());
        i_valid     = v;
        i_data      = d;
        i_cfg_valid = cv;
        i_acc_len   = len;
        if (cv && !busy_m() && v == '0) len_m = (len == 0) ? 1 : int'(len);
        if (v != '0) begin
            if (cnt_m == 0) g_sum = beat_sum(v, d);
            else            g_sum = g_sum + beat_sum(v, d);
            cnt_m++;
            last_beat = cyc;
            if (cnt_m >= len_m) begin
                exp_q.push_back(g_sum);
                exp_cyc_q.push_back(cyc + LAT);
                cnt_m = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0, '0, 1'b0, '0);
    endtask

    task automatic beat(input logic [N-1:0] v, input logic [N*IW-1:0] d);
        drive_cycle(v, d, 1'b0, '0);
    endtask

    task automatic load_len(input logic [LW-1:0] len);
        drive_cycle('0, '0, 1'b1, len);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_valid = '0; i_data = '0; i_cfg_valid = 1'b0; i_acc_len = '0;
        @(posedge clk);
        #1 model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got o_valid=1 data %h, expected no output (cycle %0d)", o_data, cyc);
                end else begin
                    check("out_data", o_data, exp_q[0]);
                    check("out_cycle", cyc, exp_cyc_q[0]);
                    last_out = exp_q[0];
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
                pulse_cnt++;
                last_seen = o_data;
            end else begin
                check("valid_known", o_valid, 1'b0);
                if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_valid: got o_valid=0, expected data %h at cycle %0d", exp_q[0], exp_cyc_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
                check("hold_data", o_data, last_out);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        string           name;
        logic [N-1:0]    valid;
        logic [N*IW-1:0] data;
        logic [OW-1:0]   exp;
    } vec_t;

    vec_t vecs[7];

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        logic [N*IW-1:0] d;
        logic [N-1:0] rv;

        rst = 1'b1;
        i_valid = '0; i_data = '0; i_cfg_valid = 1'b0; i_acc_len = '0;
        repeat (2) @(posedge clk);
        #1 model_clear();
        @(negedge clk);
        rst = 1'b0;
        check("reset_valid", o_valid, 1'b0);
        check("reset_data", o_data, '0);
        check("reset_busy", o_busy, 1'b0);
        mon_en = 1;

        for (int k = 0; k < N; k++) d[k*IW +: IW] = IW'(k + 1);
        vecs[0] = '{"sum_1_to_8", 8'hFF, d, 40'd36};
        vecs[1] = '{"mask_fives", 8'h05, all_lanes(32'h5), 40'd10};
        d = all_lanes(32'hFFFF_FFFF);
        d[31:0] = 32'h5;
        d[95:64] = 32'h5;
        vecs[2] = '{"mask_ignores_ones", 8'h05, d, 40'd10};
        d = all_lanes(32'hDEAD_BEEF);
        d[31:0] = 32'hFFFF_FFFF;
        d[63:32] = 32'h3;
        vecs[3] = '{"signed_m1_p3", 8'h03, d, 40'd2};
        vecs[4] = '{"all_max_pos", 8'hFF, all_lanes(32'h7FFF_FFFF), 40'h03_FFFF_FFF8};
        vecs[5] = '{"all_min_neg", 8'hFF, all_lanes(32'h8000_0000), 40'hFC_0000_0000};
        vecs[6] = '{"all_minus_one", 8'hFF, all_lanes(32'hFFFF_FFFF), 40'hFF_FFFF_FFF8};

        for (int i = 0; i < 7; i++) begin
            p0 = pulse_cnt;
            beat(vecs[i].valid, vecs[i].data);
            idle(5);
            check({vecs[i].name, "_pulses"}, pulse_cnt - p0, 1);
            check(vecs[i].name, last_seen, vecs[i].exp);
        end

        // acc_len=3 with a two-cycle bubble before the closing beat
        load_len(16'd3);
        p0 = pulse_cnt;
        beat(8'hFF, all_lanes(32'h2));
        beat(8'hFF, all_lanes(32'h2));
        idle(2);
        beat(8'hFF, all_lanes(32'h2));
        idle(3);
        check("len3_no_early_valid", pulse_cnt - p0, 0);
        idle(2);
        check("len3_one_pulse", pulse_cnt - p0, 1);
        check("len3_sum", last_seen, 40'd48);

        // 70 beats of maximum positive lanes wrap modulo 2^40
        load_len(16'd70);
        for (int i = 0; i < 70; i++) beat(8'hFF, all_lanes(32'h7FFF_FFFF));
        idle(5);
        check("wrap_sum", last_seen, 40'h17_FFFF_FDD0);

        // config request while a group is open is dropped
        load_len(16'd2);
        p0 = pulse_cnt;
        beat(8'hFF, all_lanes(32'h1));
        load_len(16'd5);
        beat(8'hFF, all_lanes(32'h1));
        idle(5);
        check("gated_cfg_pulse", pulse_cnt - p0, 1);
        check("gated_cfg_sum", last_seen, 40'd16);
        load_len(16'd0);
        p0 = pulse_cnt;
        beat(8'h01, all_lanes(32'h9));
        idle(5);
        check("len0_pulse", pulse_cnt - p0, 1);
        check("len0_sum", last_seen, 40'd9);

        // reset in the middle of an open group
        load_len(16'd4);
        p0 = pulse_cnt;
        beat(8'hFF, all_lanes(32'h3));
        beat(8'hFF, all_lanes(32'h3));
        idle(1);
        do_reset();
        idle(6);
        check("reset_drops_group", pulse_cnt - p0, 0);
        beat(8'h01, all_lanes(32'h7));
        idle(5);
        check("post_reset_len1", last_seen, 40'd7);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 5))
                    0:       d[k*IW +: IW] = 32'h7FFF_FFFF;
                    1:       d[k*IW +: IW] = 32'h8000_0000;
                    default: d[k*IW +: IW] = $urandom;
                endcase
            end
            rv = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            drive_cycle(rv, d, ($urandom_range(0, 7) == 0), LW'($urandom_range(0, 4)));
        end
        idle(6);
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
